trace_line_encoder: RTL and testbench



---
 rtl/trace_line_encoder.sv | 147 ++++++++++++++
 tb/tb_trace_line_encoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/trace_line_encoder.sv
// trace_line_encoder: serializes packed multi-field samples into ASCII trace lines ("0101 1010\n").
// Optional macro TRACE_LINE_TIMESTAMP_EN prefixes each line with a TS_W-bit cycle timestamp token.
module trace_line_encoder #(
  parameter int FIELD_W    = 8,
  parameter int NUM_FIELDS = 2,
  parameter int TS_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_byte,
  output logic                          busy,
  output logic [15:0]                   line_cnt
);
  localparam int DW = NUM_FIELDS * FIELD_W;
  localparam int BW = FIELD_W > 1 ? $clog2(FIELD_W) : 1;
  localparam int FW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;

  if (FIELD_W < 1 || NUM_FIELDS < 1 || TS_W < 1) begin : g_bad_params
    $error("trace_line_encoder: parameters out of range");
  end

  typedef enum logic [2:0] {IDLE, TS, TSEP, BITS, SEP, EOL} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   data_q, data_d;
  logic [FW-1:0]   fld_q, fld_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [15:0]     line_cnt_q, line_cnt_d;
  logic [FIELD_W-1:0] cur_field;

  assign cur_field = data_q[fld_q*FIELD_W +: FIELD_W];
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q != IDLE;
  assign line_cnt  = line_cnt_q;

`ifdef TRACE_LINE_TIMESTAMP_EN
  localparam int TB = TS_W > 1 ? $clog2(TS_W) : 1;
  logic [TS_W-1:0] ts_q, tsl_q, tsl_d;
  logic [TB-1:0]   tb_q, tb_d;

  // free-running cycle counter, zero in the cycle after reset
  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else ts_q <= ts_q + 1'b1;
  end

  // latched timestamp and its character index
  always_ff @(posedge clk) begin
    if (rst) begin
      tsl_q <= '0;
      tb_q  <= '0;
    end else begin
      tsl_q <= tsl_d;
      tb_q  <= tb_d;
    end
  end
`endif

  // state, sample shift register and line counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      fld_q      <= '0;
      bit_q      <= '0;
      line_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      fld_q      <= fld_d;
      bit_q      <= bit_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  // next-state and output character; everything holds while the sink stalls
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    fld_d      = fld_q;
    bit_d      = bit_q;
    line_cnt_d = line_cnt_q;
    out_byte   = 8'h00;
`ifdef TRACE_LINE_TIMESTAMP_EN
    tsl_d      = tsl_q;
    tb_d       = tb_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          fld_d  = '0;
          bit_d  = BW'(FIELD_W - 1);
`ifdef TRACE_LINE_TIMESTAMP_EN
          tsl_d   = ts_q;
          tb_d    = TB'(TS_W - 1);
          state_d = TS;
`else
          state_d = BITS;
`endif
        end
      end
`ifdef TRACE_LINE_TIMESTAMP_EN
      TS: begin
        out_byte = {7'h18, tsl_q[tb_q]};
        if (out_ready) begin
          tb_d    = |tb_q ? tb_q - 1'b1 : tb_q;
          state_d = |tb_q ? TS : TSEP;
        end
      end
      TSEP: begin
        out_byte = 8'h20;
        state_d  = out_ready ? BITS : TSEP;
      end
`endif
      BITS: begin
        out_byte = {7'h18, cur_field[bit_q]};
        if (out_ready) begin
          bit_d   = |bit_q ? bit_q - 1'b1 : bit_q;
          state_d = |bit_q ? BITS : (fld_q == FW'(NUM_FIELDS - 1) ? EOL : SEP);
        end
      end
      SEP: begin
        out_byte = 8'h20;
        if (out_ready) begin
          fld_d   = fld_q + 1'b1;
          bit_d   = BW'(FIELD_W - 1);
          state_d = BITS;
        end
      end
      EOL: begin
        out_byte = 8'h0A;
        if (out_ready) begin
          line_cnt_d = line_cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_trace_line_encoder.sv
// tb_trace_line_encoder: directed and random checks of trace_line_encoder against a queue-based line model.
module tb_trace_line_encoder;
  localparam int FW  = 4;
  localparam int NF  = 2;
  localparam int TSW = 4;
  localparam int DW  = FW * NF;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [DW-1:0] in_data;
  logic [7:0]    out_byte;
  logic [15:0]   line_cnt;

  int            n_asserts = 0;
  int            n_fail = 0;
  logic [7:0]    exp_q[$];
  logic [15:0]   cnt_exp;
  logic [TSW-1:0] mts;
  logic          held;
  logic [7:0]    held_byte;

  trace_line_encoder #(.FIELD_W(FW), .NUM_FIELDS(NF), .TS_W(TSW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .busy(busy), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // expected characters of one line: optional timestamp token, then fields low to high, MSB first
  function automatic void push_line(input logic [DW-1:0] d);
`ifdef TRACE_LINE_TIMESTAMP_EN
    for (int i = TSW - 1; i >= 0; i--) exp_q.push_back(mts[i] ? 8'h31 : 8'h30);
    exp_q.push_back(8'h20);
`endif
    for (int f = 0; f < NF; f++) begin
      for (int b = FW - 1; b >= 0; b--) exp_q.push_back(d[f*FW+b] ? 8'h31 : 8'h30);
      exp_q.push_back(f == NF - 1 ? 8'h0A : 8'h20);
    end
  endfunction

  // scoreboard: looks at the handshakes that will complete at the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cnt_exp = '0;
      mts = '0;
      held = 1'b0;
    end else begin
      chk("line_cnt", 32'(line_cnt), 32'(cnt_exp));
      if (held) chk("stall_hold", {23'd0, out_valid, out_byte}, {23'd0, 1'b1, held_byte});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'(out_byte), 32'hFFFF_FFFF);
        else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("stream_byte", 32'(out_byte), 32'(e));
          if (e == 8'h0A) cnt_exp++;
        end
      end
      held = out_valid && !out_ready;
      held_byte = out_byte;
      if (in_valid && in_ready) push_line(in_data);
      mts++;
    end
  end

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic expect_seq(input string tag, input logic [119:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, {23'd0, out_valid, out_byte}, {23'd0, 1'b1, seq[119-8*i -: 8]});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_byte", 32'(out_byte), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_line_cnt", 32'(line_cnt), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
`ifdef TRACE_LINE_TIMESTAMP_EN
    repeat (3) @(posedge clk);
    #1;
    send(8'h00);
    expect_seq("ts_line", 120'h30_30_31_31_20_30_30_30_30_20_30_30_30_30_0A, 15);
`else
    send(8'hA5);
    expect_seq("a5_line", {80'h30_31_30_31_20_31_30_31_30_0A, 40'd0}, 10);
    chk("a5_in_ready", 32'(in_ready), 32'd1);
    chk("a5_line_cnt", 32'(line_cnt), 32'd1);
`endif
    wait_idle();
    out_ready = 1'($urandom_range(0, 1));
    send(8'hA5);
    for (int i = 0; i < 200 && busy; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    wait_idle();
    chk("a5_random_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'b1;
      in_data = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    send(DW'($urandom));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_line_cnt", 32'(line_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    send(8'h0F);
`ifndef TRACE_LINE_TIMESTAMP_EN
    expect_seq("0f_line", {80'h31_31_31_31_20_30_30_30_30_0A, 40'd0}, 10);
`endif
    wait_idle();
    chk("0f_line_cnt", 32'(line_cnt), 32'd1);
    force dut.line_cnt_q = 16'hFFFF;
    cnt_exp = 16'hFFFF;
    #2;
    release dut.line_cnt_q;
    @(posedge clk); #1;
    chk("wrap_pre", 32'(line_cnt), 32'h0000_FFFF);
    send(DW'($urandom));
    wait_idle();
    chk("wrap_post", 32'(line_cnt), 32'd0);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
